// File: rtl/scope_capture_writer_pkg.sv
// Shared scope display types: FSM states, trigger modes and frame geometry.
// Also imported by the VGA renderer, so keep these encodings stable.
package scope_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } scope_state_e;

  typedef enum logic [1:0] {
    TRIG_FREE   = 2'b00,
    TRIG_RISE   = 2'b01,
    TRIG_FALL   = 2'b10,
    TRIG_SINGLE = 2'b11
  } trig_mode_e;

  localparam int unsigned SCOPE_COLS   = 640;
  localparam int unsigned SCOPE_PLOT_H = 235;
  localparam int unsigned ADDR_W       = 10;
  localparam int unsigned ROW_W        = 9;

endpackage

// File: rtl/scope_capture_writer_trigger_detect.sv
// Decimation counter, previous-kept-sample register and edge compare.
// Emits combinational keep/trig strobes for the sample presented this cycle.
module scope_trigger_detect
  import scope_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned DECIM_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic [DECIM_W-1:0]  decim,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  trig_mode_e          trig_mode,
  output logic                keep,
  output logic                trig
);

  logic [DECIM_W-1:0]  cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic                rise, fall, hit;

  always_comb begin
    // >= so a live decrease of decim below the count cannot stall keeping
    keep   = adc_valid && (cnt_q >= decim);
    cnt_d  = cnt_q;
    prev_d = prev_q;
    if (adc_valid) cnt_d = keep ? '0 : cnt_q + 1'b1;
    if (keep) prev_d = adc_data;
    rise = (prev_q < trig_level) && (adc_data >= trig_level);
    fall = (prev_q > trig_level) && (adc_data <= trig_level);
    hit  = 1'b0;
    unique case (trig_mode)
      TRIG_FREE:              hit = 1'b1;
      TRIG_RISE, TRIG_SINGLE: hit = rise;
      TRIG_FALL:              hit = fall;
      default:                hit = 1'b0;
    endcase
    trig = keep && hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      prev_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/scope_capture_writer.sv
// Writes one triggered frame of plot rows into the back bank of a ping-pong column RAM.
// Optional SCOPE_AUTO_TRIG_EN forces a trigger after AUTO_TIMEOUT kept samples in ARMED.
module scope_capture_writer
  import scope_pkg::*;
#(
  parameter int unsigned SAMPLE_W     = 8,
  parameter int unsigned COLS         = SCOPE_COLS,
  parameter int unsigned PLOT_H       = SCOPE_PLOT_H,
  parameter int unsigned DECIM_W      = 16,
  parameter int unsigned AUTO_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic [DECIM_W-1:0]  decim,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic [1:0]          trig_mode,
  input  logic                arm,
  input  logic                frame_sync,
  output logic                wr_en,
  output logic                wr_bank,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [ROW_W-1:0]    wr_row,
  output logic                disp_bank,
  output logic                busy,
  output logic                capture_done
);

  localparam int unsigned PROD_W = SAMPLE_W + ROW_W;

  scope_state_e        state_q, state_d;
  trig_mode_e          mode_q, mode_d;
  logic [ADDR_W-1:0]   col_q, col_d;
  logic                disp_q, disp_d, busy_q, busy_d, done_q, done_d;
  logic                s1_en_q, s1_en_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  logic [ROW_W-1:0]    s1_row_q, s1_row_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ROW_W-1:0]    wr_row_q, wr_row_d;
  logic                keep, trig, force_trig, auto_clr;
  logic [ROW_W-1:0]    scaled;

  scope_trigger_detect #(
    .SAMPLE_W (SAMPLE_W),
    .DECIM_W  (DECIM_W)
  ) u_trig (
    .clk        (clk),
    .rst_n      (rst_n),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .decim      (decim),
    .trig_level (trig_level),
    .trig_mode  (mode_q),
    .keep       (keep),
    .trig       (trig)
  );

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int unsigned AUTO_W = $clog2(AUTO_TIMEOUT + 1);
  logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
  logic              auto_count;

  always_comb begin
    auto_count = (state_q == ARMED) && keep && (mode_q != TRIG_FREE);
    force_trig = auto_count && (auto_cnt_q == AUTO_W'(AUTO_TIMEOUT - 1));
    auto_cnt_d = auto_cnt_q;
    if (auto_clr) auto_cnt_d = '0;
    else if (auto_count) auto_cnt_d = auto_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) auto_cnt_q <= '0;
    else        auto_cnt_q <= auto_cnt_d;
  end
`else
  logic auto_unused;
  assign force_trig  = 1'b0;
  assign auto_unused = auto_clr ^ (AUTO_TIMEOUT == 0);
`endif

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    col_d     = col_q;
    disp_d    = disp_q;
    done_d    = 1'b0;
    auto_clr  = 1'b0;
    s1_en_d   = 1'b0;
    s1_addr_d = s1_addr_q;
    s1_row_d  = s1_row_q;
    scaled    = ROW_W'((PROD_W'(adc_data) * PROD_W'(PLOT_H)) >> SAMPLE_W);
    unique case (state_q)
      IDLE: if (arm) begin
        state_d  = ARMED;
        mode_d   = trig_mode_e'(trig_mode);
        auto_clr = 1'b1;
      end
      ARMED: if (trig || force_trig) begin
        state_d   = CAPTURE;
        s1_en_d   = 1'b1;
        s1_addr_d = '0;
        col_d     = ADDR_W'(1);
      end
      CAPTURE: if (keep) begin
        s1_en_d   = 1'b1;
        s1_addr_d = col_q;
        if (col_q == ADDR_W'(COLS - 1)) begin
          state_d = DONE;
          col_d   = '0;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      DONE: if (frame_sync) begin
        disp_d = ~disp_q;
        done_d = 1'b1;
        if (mode_q == TRIG_SINGLE) begin
          state_d = IDLE;
        end else begin
          state_d  = ARMED;
          mode_d   = trig_mode_e'(trig_mode);
          auto_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (s1_en_d) s1_row_d = ROW_W'(PLOT_H - 1) - scaled;
    busy_d    = (state_d != IDLE);
    wr_en_d   = s1_en_q;
    wr_addr_d = s1_en_q ? s1_addr_q : wr_addr_q;
    wr_row_d  = s1_en_q ? s1_row_q : wr_row_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= TRIG_FREE;
      col_q     <= '0;
      disp_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s1_en_q   <= 1'b0;
      s1_addr_q <= '0;
      s1_row_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_row_q  <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      col_q     <= col_d;
      disp_q    <= disp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      s1_en_q   <= s1_en_d;
      s1_addr_q <= s1_addr_d;
      s1_row_q  <= s1_row_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_row_q  <= wr_row_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_bank      = ~disp_q;
  assign wr_addr      = wr_addr_q;
  assign wr_row       = wr_row_q;
  assign disp_bank    = disp_q;
  assign busy         = busy_q;
  assign capture_done = done_q;

endmodule
